spm_boot_memory: RTL and testbench
==================================

# spm_boot_memory

Parametrised program/data memory for the RISC_SPM family with a built-in boot loader.
- After reset it clears the array, then accepts program and data words over a valid/ready load stream, then releases the processor from reset.
- It replaces hierarchical pokes into the memory array from benches and gives real systems a load path.
- It sits between the load source (bench driver, UART bridge, ROM streamer) and the processor's memory port.

## Interface
Parameters:
- WORD_SIZE, 8, data word width in bits.
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH.
- CLEAR_ON_RESET, 1. When 1, zero every location after reset. When 0, skip straight to LOAD.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- load_valid  in  1  load word present.
- load_ready  out  1  loader accepts a word this cycle.
- load_addr  in  ADDR_WIDTH  target address of load word.
- load_data  in  WORD_SIZE  load word.
- load_last  in  1  marks final word of the image.
- reload  in  1  single-cycle request to re-enter LOAD from RUN.
- cpu_rst_n  out  1  active-low reset to the processor; low except in RUN.
- cpu_addr  in  ADDR_WIDTH  processor address.
- cpu_din  in  WORD_SIZE  processor write data.
- cpu_write  in  1  processor write enable.
- cpu_dout  out  WORD_SIZE  processor read data, combinational from cpu_addr.
- probe_addr  in  ADDR_WIDTH  debug read address.
- probe_data  out  WORD_SIZE  combinational debug read.
- busy  out  1  high in CLEAR.
- words_loaded  out  ADDR_WIDTH+1  accepted load words since last entry to LOAD; saturates at DEPTH.

## Operation
- States: CLEAR, LOAD, RUN.
- On rst:
  - Next state is CLEAR when CLEAR_ON_RESET=1, otherwise LOAD.
  - clr_ptr=0, words_loaded=0.
- Reset values of outputs: cpu_rst_n=0, load_ready=0, busy=1 (0 if CLEAR_ON_RESET=0), words_loaded=0.
- CLEAR:
  - Writes 0 to mem[clr_ptr] each cycle and increments clr_ptr.
  - After writing DEPTH-1, goes to LOAD.
  - load_ready=0; cpu writes are ignored.
- LOAD:
  - load_ready=1.
  - A handshake (load_valid & load_ready) writes load_data to mem[load_addr] and increments words_loaded, saturating.
  - A handshake with load_last=1 goes to RUN.
  - cpu writes are ignored. Repeated addresses: last write wins.
- RUN:
  - load_ready=0, cpu_rst_n=1.
  - cpu_write writes cpu_din to mem[cpu_addr].
  - reload=1 goes to LOAD, clears words_loaded and does not clear the array.
  - reload together with cpu_write: the write is performed in that cycle, then the block goes to LOAD.
- reload outside RUN is ignored.
- rst in any state, including mid-CLEAR or mid-LOAD, restarts from the reset state. Partial contents are re-zeroed when CLEAR_ON_RESET=1.
- Reads on cpu_dout and probe_data are asynchronous in every state. They return pre-edge contents during a same-cycle write.

## Timing
- Clear latency: DEPTH cycles after the first clock with rst low. load_ready rises on cycle DEPTH+1.
- Load: one word per cycle maximum, zero-bubble.
- cpu_rst_n rises on the edge that accepts the load_last word. The processor sees reset released from the next cycle.
- reload: cpu_rst_n falls on the edge sampling reload=1; load_ready=1 in the same following cycle.
- Write-to-read: a value written at edge N is visible on cpu_dout/probe_data after edge N.

## Structure
- Package spm_pkg holds:
  - the state typedef (ST_CLEAR, ST_LOAD, ST_RUN);
  - default WORD_SIZE/ADDR_WIDTH constants shared with RISC_SPM.
- Sub-module spm_sram_core:
  - DEPTH×WORD_SIZE array with one write port and two asynchronous read ports (cpu, probe).
  - The FSM in the parent muxes the write port between the clear, load and cpu sources.

## Test plan
Defaults 8/8/1.
- rst high 2 cycles, then low:
  - busy=1 for 256 cycles, then load_ready=1.
  - probe of addr 0, 128, 255 reads 0; cpu_rst_n=0 throughout.
- Stream image (1:0x52, 2:130, 128:6, 129:1, 130:2, 139:0xF0, 140:9 with load_last):
  - cpu_rst_n=1 the cycle after the last handshake; words_loaded=7.
  - probe 139 reads 0xF0.
- load_valid held high during CLEAR: no write before load_ready.
- Then 0xAA at addr 5 is accepted on the first LOAD cycle; probe 5 reads 0xAA after.
- RUN:
  - cpu_write addr 131 data 12 sets cpu_dout 12 after the edge.
  - Earlier cpu_write 131←99 issued during LOAD left the location at 0.
- RUN, reload with cpu_write addr 128 data 3 in the same cycle:
  - mem[128]=3; cpu_rst_n=0 and load_ready=1 next cycle; words_loaded=0.
- rst after 5 load words mid-LOAD: words_loaded=0, 256-cycle clear repeats, all 5 addresses read 0.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared definitions for the RISC_SPM boot memory: FSM state encoding
// and the default memory geometry used across the RISC_SPM family.
package spm_pkg;

    localparam int SPM_WORD_SIZE  = 8;
    localparam int SPM_ADDR_WIDTH = 8;

    typedef logic [1:0] spm_state_t;

    localparam spm_state_t ST_CLEAR = 2'd0;
    localparam spm_state_t ST_LOAD  = 2'd1;
    localparam spm_state_t ST_RUN   = 2'd2;

endpackage

// File: rtl/spm_sram_core.sv
// DEPTH x WORD_SIZE storage array with one synchronous write port and two
// asynchronous read ports (processor side and debug probe side).
module spm_sram_core #(
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_SIZE-1:0]  wdata,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [WORD_SIZE-1:0]  cpu_dout,
    input  logic [ADDR_WIDTH-1:0] probe_addr,
    output logic [WORD_SIZE-1:0]  probe_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see pre-edge contents during a same-cycle write.
    assign cpu_dout   = mem[cpu_addr];
    assign probe_data = mem[probe_addr];

endmodule

// File: rtl/spm_boot_memory.sv
// Program/data memory with a built-in boot loader: clears the array, accepts
// an image over a valid/ready stream, then releases the processor from reset.
module spm_boot_memory
    import spm_pkg::*;
#(
    parameter int WORD_SIZE      = SPM_WORD_SIZE,
    parameter int ADDR_WIDTH     = SPM_ADDR_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [WORD_SIZE-1:0]  load_data,
    input  logic                  load_last,
    input  logic                  reload,
    output logic                  cpu_rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_din,
    input  logic                  cpu_write,
    output logic [WORD_SIZE-1:0]  cpu_dout,
    input  logic [ADDR_WIDTH-1:0] probe_addr,
    output logic [WORD_SIZE-1:0]  probe_data,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output spm_state_t            state
);

    localparam spm_state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST    = '1;
    localparam logic [ADDR_WIDTH:0]   WORDS_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};

    spm_state_t            state_q;
    spm_state_t            state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [ADDR_WIDTH:0]   words_cnt;
    logic                  load_fire;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WORD_SIZE-1:0]  mem_wdata;

    // Handshake: a load word transfers on a rising edge where load_valid and
    // load_ready are both high; load_ready depends only on state and rst, never
    // on load_valid, and the source must hold its word until it transfers.
    assign load_ready   = (state_q == ST_LOAD) && !rst;
    assign load_fire    = load_valid && load_ready;
    assign cpu_rst_n    = (state_q == ST_RUN) && !rst;
    assign busy         = rst ? CLEAR_ON_RESET : (state_q == ST_CLEAR);
    assign words_loaded = words_cnt;
    assign state        = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr == CLR_LAST) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_fire && load_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // The single write port is owned by whichever phase the loader is in,
    // so processor writes outside RUN never reach the array.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        if (!rst) begin
            case (state_q)
                ST_CLEAR: begin
                    mem_we = 1'b1;
                end
                ST_LOAD: begin
                    mem_we    = load_fire;
                    mem_waddr = load_addr;
                    mem_wdata = load_data;
                end
                ST_RUN: begin
                    mem_we    = cpu_write;
                    mem_waddr = cpu_addr;
                    mem_wdata = cpu_din;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            clr_ptr   <= '0;
            words_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (state_q == ST_RUN && reload) begin
                words_cnt <= '0;
            end else if (load_fire && words_cnt != WORDS_MAX) begin
                words_cnt <= words_cnt + 1'b1;
            end
        end
    end

    spm_sram_core #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk        (clk),
        .we         (mem_we),
        .waddr      (mem_waddr),
        .wdata      (mem_wdata),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .probe_addr (probe_addr),
        .probe_data (probe_data)
    );

endmodule

// File: tb/tb_spm_boot_memory.sv
// Self-checking bench for spm_boot_memory with default 8/8/1 parameters,
// using a reference memory image and load counter kept in the bench.
module tb_spm_boot_memory;

    localparam int W     = 8;
    localparam int A     = 8;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [A-1:0] load_addr;
    logic [W-1:0] load_data;
    logic         load_last;
    logic         reload;
    logic         cpu_rst_n;
    logic [A-1:0] cpu_addr;
    logic [W-1:0] cpu_din;
    logic         cpu_write;
    logic [W-1:0] cpu_dout;
    logic [A-1:0] probe_addr;
    logic [W-1:0] probe_data;
    logic         busy;
    logic [A:0]   words_loaded;
    logic [1:0]   dut_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] ref_mem [DEPTH];
    int           ref_words;
    logic [W-1:0] exp_q [$];
    logic [A-1:0] addr_q [$];

    always #5 clk = ~clk;

    spm_boot_memory #(
        .WORD_SIZE      (W),
        .ADDR_WIDTH     (A),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_last    (load_last),
        .reload       (reload),
        .cpu_rst_n    (cpu_rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cpu_write    (cpu_write),
        .cpu_dout     (cpu_dout),
        .probe_addr   (probe_addr),
        .probe_data   (probe_data),
        .busy         (busy),
        .words_loaded (words_loaded),
        .state        (dut_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_last  = 1'b0;
        reload     = 1'b0;
        cpu_addr   = '0;
        cpu_din    = '0;
        cpu_write  = 1'b0;
        probe_addr = '0;
    endtask

    task automatic model_load(input logic [A-1:0] a, input logic [W-1:0] d);
        ref_mem[a] = d;
        ref_words  = (ref_words < DEPTH) ? ref_words + 1 : DEPTH;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %0b want 1", busy); end
        n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL reset_load_ready: got %0b want 0", load_ready); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_rst_n: got %0b want 0", cpu_rst_n); end
        n_cmp++; if (words_loaded !== 9'd0) begin n_bad++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
        rst = 1'b0;
        n = 0;
        bad = 0;
        while (busy === 1'b1 && n < 400) begin
            if (cpu_rst_n !== 1'b0 || load_ready !== 1'b0) bad++;
            tick();
            n++;
        end
        n_cmp++; if (n != DEPTH) begin n_bad++; $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clear_outputs: got %0d bad cycles want 0", bad); end
        n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL clear_done_ready: got %0b want 1", load_ready); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_words = 0;
        addr_q = '{8'd0, 8'd128, 8'd255};
        while (addr_q.size() > 0) begin
            probe_addr = addr_q.pop_front();
            #1;
            n_cmp++; if (probe_data !== 8'h00) begin n_bad++; $display("FAIL clear_probe[%0d]: got %0h want 0", probe_addr, probe_data); end
        end
    endtask

    task automatic test_load_image();
        int img_a [7] = '{1, 2, 128, 129, 130, 139, 140};
        int img_d [7] = '{8'h52, 130, 6, 1, 2, 8'hF0, 9};
        cpu_write = 1'b1;
        cpu_addr  = 8'd131;
        cpu_din   = 8'd99;
        for (int i = 0; i < 7; i++) begin
            load_valid = 1'b1;
            load_addr  = A'(img_a[i]);
            load_data  = W'(img_d[i]);
            load_last  = (i == 6);
            #1;
            n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL image_ready[%0d]: got %0b want 1", i, load_ready); end
            n_cmp++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL image_cpu_rst_n[%0d]: got %0b want 0", i, cpu_rst_n); end
            tick();
            model_load(A'(img_a[i]), W'(img_d[i]));
        end
        idle_inputs();
        #1;
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_bad++; $display("FAIL image_release: got %0b want 1", cpu_rst_n); end
        n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL image_ready_drop: got %0b want 0", load_ready); end
        n_cmp++; if (words_loaded !== 9'(ref_words)) begin n_bad++; $display("FAIL image_words: got %0d want %0d", words_loaded, ref_words); end
        for (int i = 0; i < 7; i++) begin
            addr_q.push_back(A'(img_a[i]));
            exp_q.push_back(ref_mem[img_a[i]]);
        end
        addr_q.push_back(8'd131);
        exp_q.push_back(ref_mem[131]);
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            probe_addr = addr_q.pop_front();
            e = exp_q.pop_front();
            #1;
            n_cmp++; if (probe_data !== e) begin n_bad++; $display("FAIL image_probe[%0d]: got %0h want %0h", probe_addr, probe_data, e); end
            tick();
        end
    endtask

    task automatic test_run_write();
        logic [A-1:0] a;
        logic [W-1:0] d;
        logic         we;
        cpu_write = 1'b1;
        cpu_addr  = 8'd131;
        cpu_din   = 8'd12;
        #1;
        n_cmp++; if (cpu_dout !== ref_mem[131]) begin n_bad++; $display("FAIL run_pre_edge: got %0h want %0h", cpu_dout, ref_mem[131]); end
        tick();
        ref_mem[131] = 8'd12;
        cpu_write = 1'b0;
        #1;
        n_cmp++; if (cpu_dout !== 8'd12) begin n_bad++; $display("FAIL run_write_131: got %0d want 12", cpu_dout); end
        for (int i = 0; i < 40; i++) begin
            a  = A'($urandom_range(0, DEPTH - 1));
            d  = W'($urandom_range(0, 255));
            we = 1'($urandom_range(0, 1));
            cpu_addr  = a;
            cpu_din   = d;
            cpu_write = we;
            #1;
            n_cmp++; if (cpu_dout !== ref_mem[a]) begin n_bad++; $display("FAIL run_read[%0d]: got %0h want %0h", a, cpu_dout, ref_mem[a]); end
            tick();
            if (we) ref_mem[a] = d;
            cpu_write  = 1'b0;
            probe_addr = A'($urandom_range(0, DEPTH - 1));
            #1;
            n_cmp++; if (probe_data !== ref_mem[probe_addr]) begin n_bad++; $display("FAIL run_probe[%0d]: got %0h want %0h", probe_addr, probe_data, ref_mem[probe_addr]); end
        end
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_bad++; $display("FAIL run_cpu_rst_n: got %0b want 1", cpu_rst_n); end
    endtask

    task automatic test_reload_with_write();
        logic [W-1:0] d;
        cpu_write = 1'b1;
        cpu_addr  = 8'd128;
        cpu_din   = 8'd3;
        reload    = 1'b1;
        tick();
        ref_mem[128] = 8'd3;
        ref_words    = 0;
        idle_inputs();
        probe_addr = 8'd128;
        #1;
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL reload_cpu_rst_n: got %0b want 0", cpu_rst_n); end
        n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reload_ready: got %0b want 1", load_ready); end
        n_cmp++; if (words_loaded !== 9'd0) begin n_bad++; $display("FAIL reload_words: got %0d want 0", words_loaded); end
        n_cmp++; if (probe_data !== 8'd3) begin n_bad++; $display("FAIL reload_write_128: got %0d want 3", probe_data); end
        probe_addr = 8'd139;
        #1;
        n_cmp++; if (probe_data !== ref_mem[139]) begin n_bad++; $display("FAIL reload_keeps_139: got %0h want %0h", probe_data, ref_mem[139]); end
        d = W'($urandom_range(0, 255));
        load_valid = 1'b1;
        load_addr  = 8'd7;
        load_data  = d;
        tick();
        model_load(8'd7, d);
        load_valid = 1'b0;
        reload     = 1'b1;
        tick();
        reload = 1'b0;
        #1;
        n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reload_in_load_ready: got %0b want 1", load_ready); end
        n_cmp++; if (words_loaded !== 9'(ref_words)) begin n_bad++; $display("FAIL reload_in_load_words: got %0d want %0d", words_loaded, ref_words); end
    endtask

    task automatic test_random_load();
        int hs;
        int cyc;
        int bad;
        logic         v;
        logic [A-1:0] a;
        logic [W-1:0] d;
        hs  = 0;
        cyc = 0;
        bad = 0;
        while (hs < 300 && cyc < 2000) begin
            v = ($urandom_range(0, 3) != 0);
            a = A'($urandom_range(0, DEPTH - 1));
            d = W'($urandom_range(0, 255));
            load_valid = v;
            load_addr  = a;
            load_data  = d;
            load_last  = 1'b0;
            cpu_write  = 1'($urandom_range(0, 1));
            cpu_addr   = A'($urandom_range(0, DEPTH - 1));
            cpu_din    = W'($urandom_range(0, 255));
            #1;
            if (load_ready !== 1'b1) bad++;
            tick();
            if (v) begin
                model_load(a, d);
                hs++;
            end
            cyc++;
            if (words_loaded !== 9'(ref_words)) bad++;
        end
        idle_inputs();
        n_cmp++; if (hs != 300) begin n_bad++; $display("FAIL rand_handshakes: got %0d want 300", hs); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rand_load_track: got %0d bad cycles want 0", bad); end
        n_cmp++; if (words_loaded !== 9'd256) begin n_bad++; $display("FAIL rand_words_sat: got %0d want 256", words_loaded); end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(ref_mem[i]);
        for (int i = 0; i < DEPTH; i++) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            probe_addr = A'(i);
            cpu_addr   = A'(i);
            #1;
            n_cmp++; if (probe_data !== e) begin n_bad++; $display("FAIL rand_probe[%0d]: got %0h want %0h", i, probe_data, e); end
            n_cmp++; if (cpu_dout !== e) begin n_bad++; $display("FAIL rand_cpu_dout[%0d]: got %0h want %0h", i, cpu_dout, e); end
            tick();
        end
        d = W'($urandom_range(0, 255));
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_addr  = 8'd200;
        load_data  = d;
        tick();
        model_load(8'd200, d);
        idle_inputs();
        probe_addr = 8'd200;
        #1;
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_bad++; $display("FAIL rand_release: got %0b want 1", cpu_rst_n); end
        n_cmp++; if (probe_data !== d) begin n_bad++; $display("FAIL rand_last_word: got %0h want %0h", probe_data, d); end
    endtask

    task automatic test_reset_mid_load();
        int n;
        int bad;
        logic [A-1:0] mid_a [5] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        logic [W-1:0] d;
        reload = 1'b1;
        tick();
        reload    = 1'b0;
        ref_words = 0;
        for (int i = 0; i < 5; i++) begin
            d = W'($urandom_range(0, 255)) | 8'h01;
            load_valid = 1'b1;
            load_addr  = mid_a[i];
            load_data  = d;
            tick();
            model_load(mid_a[i], d);
        end
        load_valid = 1'b0;
        probe_addr = 8'd30;
        #1;
        n_cmp++; if (words_loaded !== 9'd5) begin n_bad++; $display("FAIL mid_words: got %0d want 5", words_loaded); end
        n_cmp++; if (probe_data !== ref_mem[30]) begin n_bad++; $display("FAIL mid_probe_30: got %0h want %0h", probe_data, ref_mem[30]); end
        rst        = 1'b1;
        load_valid = 1'b1;
        load_addr  = 8'd5;
        load_data  = 8'hAA;
        tick();
        n_cmp++; if (words_loaded !== 9'd0) begin n_bad++; $display("FAIL mid_rst_words: got %0d want 0", words_loaded); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_rst_busy: got %0b want 1", busy); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL mid_rst_cpu_rst_n: got %0b want 0", cpu_rst_n); end
        rst = 1'b0;
        n   = 0;
        bad = 0;
        while (busy === 1'b1 && n < 400) begin
            if (load_ready !== 1'b0) bad++;
            tick();
            n++;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_words = 0;
        n_cmp++; if (n != DEPTH) begin n_bad++; $display("FAIL mid_clear_cycles: got %0d want %0d", n, DEPTH); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mid_clear_ready: got %0d bad cycles want 0", bad); end
        probe_addr = 8'd5;
        #1;
        n_cmp++; if (probe_data !== 8'h00) begin n_bad++; $display("FAIL valid_in_clear_5: got %0h want 0", probe_data); end
        tick();
        model_load(8'd5, 8'hAA);
        load_valid = 1'b0;
        #1;
        n_cmp++; if (probe_data !== 8'hAA) begin n_bad++; $display("FAIL first_load_5: got %0h want aa", probe_data); end
        n_cmp++; if (words_loaded !== 9'(ref_words)) begin n_bad++; $display("FAIL first_load_words: got %0d want %0d", words_loaded, ref_words); end
        for (int i = 0; i < 5; i++) begin
            probe_addr = mid_a[i];
            #1;
            n_cmp++; if (probe_data !== ref_mem[mid_a[i]]) begin n_bad++; $display("FAIL mid_rezero[%0d]: got %0h want %0h", mid_a[i], probe_data, ref_mem[mid_a[i]]); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_image();
        test_run_write();
        test_reload_with_write();
        test_random_load();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
